// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, MIPS opcode constants and the
// decode helpers used by the multi-cycle PC sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        UPDATE    = 3'd5,
        ERROR     = 3'd6
    } seqState_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0]  FUNCT_JR  = 6'h08;
    localparam logic [31:0] INSTR_LEN = 32'd4;

    // True for every opcode the core implements; anything else is a nop.
    function automatic logic opIsKnown(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: known = 1'b1;
            default:                               known = 1'b0;
        endcase
        return known;
    endfunction

    // State that follows EXECUTE for a given instruction.
    function automatic seqState_t execRoute(input logic [5:0] op, input logic [5:0] fn);
        seqState_t route;
        route = WRITEBACK;
        if (!opIsKnown(op)) begin
            route = UPDATE;
        end else begin
            case (op)
                OP_LW, OP_SW:        route = MEMORY;
                OP_BEQ, OP_BNE, OP_J: route = UPDATE;
                OP_RTYPE:            route = (fn == FUNCT_JR) ? UPDATE : WRITEBACK;
                default:             route = WRITEBACK;
            endcase
        end
        return route;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction/data memory handshake plus the IR capture
// strobe. master = sequencer side, slave = memory/IR side.
interface pc_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic ir_load;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, ir_load, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, ir_load, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC target (PC+4, taken branch, j/jal,
// jr). Unknown opcodes fall through to PC+4.
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pcIn,
    input  logic [15:0] imm,
    input  logic [25:0] jtarget,
    input  logic [31:0] rsValue,
    input  logic        aluZero,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [31:0] target
);

    logic [31:0]        pcPlus4;
    logic signed [31:0] brOffset;

    assign pcPlus4  = pcIn + INSTR_LEN;
    assign brOffset = {{14{imm[15]}}, imm, 2'b00};

    // Select the target according to the instruction class.
    always_comb begin
        target = pcPlus4;
        case (opcode)
            OP_BEQ:       if (aluZero)  target = pcPlus4 + brOffset;
            OP_BNE:       if (!aluZero) target = pcPlus4 + brOffset;
            OP_J, OP_JAL: target = {pcPlus4[31:28], jtarget, 2'b00};
            OP_RTYPE:     if (funct == FUNCT_JR) target = rsValue;
            default:      target = pcPlus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/UPDATE
// control for the non-pipelined MIPS core. Drives the PC register load
// strobe and registered next-PC value.
// Optional macro PC_MISALIGN_TRAP_EN: a misaligned computed target traps
// to ERROR instead of having its low two bits cleared.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter int          TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_sequencer_if.master      memIf,
    input  logic [31:0]         pc_in,
    output logic [31:0]         pc_next,
    output logic                pc_load,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [15:0]         imm,
    input  logic [25:0]         jtarget,
    input  logic [31:0]         rs_value,
    input  logic                alu_zero,
    output logic                rf_we,
    output logic [2:0]          state,
    output logic                illegal_op,
    output logic                error,
    output logic [CNT_W-1:0]    instr_count
);

    seqState_t   stateQ;
    seqState_t   stateNext;
    logic [7:0]  waitCnt;
    logic        waiting;
    logic        waitTimeout;
    logic [31:0] target;
    logic        isStoreQ;
    logic        setIllegal;
    logic        setError;
    logic        loadTarget;

    pc_next_calc uCalc (
        .pcIn    (pc_in),
        .imm     (imm),
        .jtarget (jtarget),
        .rsValue (rs_value),
        .aluZero (alu_zero),
        .opcode  (opcode),
        .funct   (funct),
        .target  (target)
    );

    // A wait cycle is any request cycle that ends without ready.
    assign waiting = ((stateQ == FETCH)  && !memIf.imem_ready) ||
                     ((stateQ == MEMORY) && !memIf.dmem_ready);
    // Ready is tested before this, so ready on the last allowed cycle wins.
    assign waitTimeout = (waitCnt == 8'(TIMEOUT - 1));

    // Reset parks the FSM in FETCH; gating with rst_n keeps the fetch
    // request low while reset is still asserted.
    assign memIf.imem_req = rst_n && (stateQ == FETCH);
    assign memIf.ir_load  = memIf.imem_req && memIf.imem_ready;
    assign memIf.dmem_req = (stateQ == MEMORY);
    assign memIf.dmem_we  = (stateQ == MEMORY) && isStoreQ;
    assign rf_we          = (stateQ == WRITEBACK);
    assign state          = stateQ;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= FETCH;
        else        stateQ <= stateNext;
    end

    // Next-state decode and one-shot control events.
    always_comb begin
        stateNext  = stateQ;
        setIllegal = 1'b0;
        setError   = 1'b0;
        loadTarget = 1'b0;
        case (stateQ)
            FETCH: begin
                if (memIf.imem_ready) begin
                    stateNext = DECODE;
                end else if (waitTimeout) begin
                    stateNext = ERROR;
                    setError  = 1'b1;
                end
            end
            DECODE: begin
                stateNext  = EXECUTE;
                setIllegal = !opIsKnown(opcode);
            end
            EXECUTE: begin
                loadTarget = 1'b1;
                stateNext  = execRoute(opcode, funct);
`ifdef PC_MISALIGN_TRAP_EN
                if (target[1:0] != 2'b00) begin
                    loadTarget = 1'b0;
                    stateNext  = ERROR;
                    setError   = 1'b1;
                end
`endif
            end
            MEMORY: begin
                if (memIf.dmem_ready) begin
                    stateNext = isStoreQ ? UPDATE : WRITEBACK;
                end else if (waitTimeout) begin
                    stateNext = ERROR;
                    setError  = 1'b1;
                end
            end
            WRITEBACK: stateNext = UPDATE;
            UPDATE:    stateNext = FETCH;
            ERROR:     stateNext = ERROR;
            default:   stateNext = FETCH;
        endcase
    end

    // Memory wait counter, cleared whenever a request is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       waitCnt <= 8'd0;
        else if (waiting) waitCnt <= waitCnt + 8'd1;
        else              waitCnt <= 8'd0;
    end

    // Next-PC, load strobe, retired count and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next     <= RESET_PC;
            pc_load     <= 1'b0;
            isStoreQ    <= 1'b0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
            error       <= 1'b0;
        end else begin
            // Low bits cleared: only a misaligned jr target can set them.
            if (loadTarget) begin
                pc_next  <= target & 32'hFFFF_FFFC;
                isStoreQ <= (opcode == OP_SW);
            end
            pc_load <= (stateNext == UPDATE);
            if (stateNext == UPDATE) instr_count <= instr_count + CNT_W'(1);
            if (setIllegal) illegal_op <= 1'b1;
            if (setError)   error      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + randomized checks of pc_sequencer against an
// instruction-level reference model (latency, target, strobe counts).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          TIMEOUT  = 255;
    localparam int          BUDGET   = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] pc_next;
    logic        pc_load;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] jtarget = '0;
    logic [31:0] rs_value = '0;
    logic        alu_zero = 1'b0;
    logic        rf_we;
    logic [2:0]  stateDbg;
    logic        illegal_op;
    logic        error;
    logic [31:0] instr_count;

    pc_sequencer_if memIf();

    pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .memIf(memIf),
        .pc_in(pc_in), .pc_next(pc_next), .pc_load(pc_load),
        .opcode(opcode), .funct(funct), .imm(imm), .jtarget(jtarget),
        .rs_value(rs_value), .alu_zero(alu_zero), .rf_we(rf_we),
        .state(stateDbg), .illegal_op(illegal_op), .error(error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] expCount = '0;

    int irCycle, rfFirst, rfCnt, dReqCnt, weCnt, loadCycle, errCycle;
    logic [31:0] pcSeen, cntSeen;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic refKnown(input logic [5:0] op);
        logic [5:0] ops [12] = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                                 OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] refNext(input logic [5:0] op, input logic [5:0] fn,
            input logic [31:0] pc, input logic [15:0] im, input logic [25:0] jt,
            input logic [31:0] rs, input logic z);
        logic [31:0] seq;
        shortint     s;
        int          off;
        seq = pc + 32'd4;
        s   = im;
        off = s;
        if ((op == OP_BEQ && z) || (op == OP_BNE && !z)) return seq + 32'(off * 4);
        if (op == OP_J || op == OP_JAL) return (seq & 32'hF000_0000) + 32'(jt) * 32'd4;
        if (op == OP_RTYPE && fn == FUNCT_JR) return rs & 32'hFFFF_FFFC;
        return seq;
    endfunction

    function automatic logic refWrites(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) return fn != FUNCT_JR;
        return op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI ||
               op == OP_LUI  || op == OP_LW   || op == OP_JAL;
    endfunction

    function automatic int refLatency(input logic [5:0] op, input logic [5:0] fn,
                                      input int iW, input int dW);
        if (!refKnown(op)) return 4 + iW;
        if (op == OP_LW)   return 6 + iW + dW;
        if (op == OP_SW)   return 5 + iW + dW;
        if (refWrites(op, fn)) return 5 + iW;
        return 4 + iW;
    endfunction

    // Run one instruction from FETCH, acting as both memories. Cycle 1 is
    // the first FETCH cycle; stops at pc_load, error or the cycle budget.
    task automatic runInstr(input int iWait, input int dWait);
        int iSeen, dSeen;
        iSeen = 0; dSeen = 0;
        irCycle = 0; rfFirst = 0; rfCnt = 0; dReqCnt = 0; weCnt = 0;
        loadCycle = 0; errCycle = 0; pcSeen = '0; cntSeen = '0;
        for (int c = 1; c <= BUDGET; c++) begin
            #1;
            memIf.imem_ready = memIf.imem_req && (iSeen == iWait);
            memIf.dmem_ready = memIf.dmem_req && (dSeen == dWait);
            #1;
            if (memIf.imem_req && !memIf.imem_ready) iSeen++;
            if (memIf.dmem_req && !memIf.dmem_ready) dSeen++;
            if (memIf.ir_load && irCycle == 0) irCycle = c;
            if (rf_we) begin
                rfCnt++;
                if (rfFirst == 0) rfFirst = c;
            end
            if (memIf.dmem_req) dReqCnt++;
            if (memIf.dmem_we)  weCnt++;
            if (pc_load) begin
                loadCycle = c; pcSeen = pc_next; cntSeen = instr_count;
            end
            if (error && errCycle == 0) errCycle = c;
            @(negedge clk);
            if (loadCycle != 0 || errCycle != 0) break;
        end
        memIf.imem_ready = 1'b0;
        memIf.dmem_ready = 1'b0;
    endtask

    task automatic doInstr(input string tag, input logic [5:0] op, input logic [5:0] fn,
            input logic [31:0] pc, input logic [15:0] im, input logic [25:0] jt,
            input logic [31:0] rs, input logic z, input int iW, input int dW);
        int  lat;
        logic isMem, wr;
        opcode = op; funct = fn; pc_in = pc; imm = im; jtarget = jt;
        rs_value = rs; alu_zero = z;
        runInstr(iW, dW);
        expCount = expCount + 32'd1;
        lat   = refLatency(op, fn, iW, dW);
        isMem = refKnown(op) && (op == OP_LW || op == OP_SW);
        wr    = refKnown(op) && refWrites(op, fn);
        check32({tag, ".irLoad"},  32'(irCycle),   32'(iW + 1));
        check32({tag, ".pcLoad"},  32'(loadCycle), 32'(lat));
        check32({tag, ".pcNext"},  pcSeen, refNext(op, fn, pc, im, jt, rs, z));
        check32({tag, ".rfCnt"},   32'(rfCnt),     wr ? 32'd1 : 32'd0);
        check32({tag, ".rfAt"},    32'(rfFirst),   wr ? 32'(lat - 1) : 32'd0);
        check32({tag, ".dmemReq"}, 32'(dReqCnt),   isMem ? 32'(dW + 1) : 32'd0);
        check32({tag, ".dmemWe"},  32'(weCnt),     (isMem && op == OP_SW) ? 32'(dW + 1) : 32'd0);
        check32({tag, ".count"},   cntSeen, expCount);
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expCount = '0;
    endtask

    initial begin
        logic [5:0] opList [12] = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                                    OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
        logic [5:0] rop, rfn;
        memIf.imem_ready = 1'b0;
        memIf.dmem_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check32("rst.state",   32'(stateDbg), 32'(FETCH));
        check32("rst.pcNext",  pc_next, RESET_PC);
        check32("rst.count",   instr_count, 32'd0);
        check32("rst.strobes", {28'd0, pc_load, memIf.imem_req, memIf.dmem_req, rf_we}, 32'd0);
        check32("rst.flags",   {30'd0, error, illegal_op}, 32'd0);
        rst_n = 1'b1;

        // Directed instructions
        doInstr("addi", OP_ADDI, 6'h00, 32'h0, 16'h0001, 26'h0, 32'h0, 1'b0, 0, 0);
        doInstr("beqT", OP_BEQ, 6'h00, 32'h100, 16'hFFFF, 26'h0, 32'h0, 1'b1, 0, 0);
        doInstr("beqN", OP_BEQ, 6'h00, 32'h100, 16'hFFFF, 26'h0, 32'h0, 1'b0, 0, 0);
        doInstr("bneT", OP_BNE, 6'h00, 32'h200, 16'h0010, 26'h0, 32'h0, 1'b0, 1, 0);
        doInstr("j",    OP_J,   6'h00, 32'hF000_0010, 16'h0, 26'h0000040, 32'h0, 1'b0, 0, 0);
        doInstr("jal",  OP_JAL, 6'h00, 32'hF000_0010, 16'h0, 26'h0000040, 32'h0, 1'b0, 0, 0);
        doInstr("lwW3", OP_LW,  6'h00, 32'h40, 16'h0, 26'h0, 32'h0, 1'b0, 0, 3);
        doInstr("sw",   OP_SW,  6'h00, 32'h44, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);
        doInstr("rAdd", OP_RTYPE, 6'h20, 32'hFFFF_FFFC, 16'h0, 26'h0, 32'h0, 1'b0, 2, 0);

        // Randomized instructions
        for (int n = 0; n < 24; n++) begin
            rop = opList[$urandom_range(0, 11)];
            rfn = 6'($urandom);
            if (rop == OP_RTYPE && $urandom_range(0, 3) == 0) rfn = FUNCT_JR;
            doInstr("rand", rop, rfn, $urandom & 32'hFFFF_FFFC, 16'($urandom),
                    26'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Misaligned jr target
`ifdef PC_MISALIGN_TRAP_EN
        opcode = OP_RTYPE; funct = FUNCT_JR; pc_in = 32'h80; rs_value = 32'h102;
        runInstr(0, 0);
        check32("jrMis.noLoad", 32'(loadCycle), 32'd0);
        check32("jrMis.errAt",  32'(errCycle), 32'd4);
        check32("jrMis.state",  32'(stateDbg), 32'(ERROR));
        resetPulse();
`else
        doInstr("jrMis", OP_RTYPE, FUNCT_JR, 32'h80, 16'h0, 26'h0, 32'h102, 1'b0, 0, 0);
        check32("jrMis.value", pcSeen, 32'h100);
`endif

        // Unknown opcode behaves as a nop and sets the sticky flag
        doInstr("illegal", 6'h3F, 6'h00, 32'h300, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);
        check32("illegal.flag", 32'(illegal_op), 32'd1);
        check32("illegal.err",  32'(error), 32'd0);

        // Ready on the last allowed wait cycle still succeeds
        doInstr("tmoEdge", OP_ADDI, 6'h00, 32'h400, 16'h0, 26'h0, 32'h0, 1'b0, TIMEOUT - 1, 0);
        check32("tmoEdge.err", 32'(error), 32'd0);

        // Timeout: ready never arrives
        opcode = OP_ADDI; pc_in = 32'h500;
        runInstr(TIMEOUT, 0);
        check32("tmo.noLoad", 32'(loadCycle), 32'd0);
        check32("tmo.errAt",  32'(errCycle), 32'(TIMEOUT + 1));
        check32("tmo.state",  32'(stateDbg), 32'(ERROR));
        repeat (3) @(negedge clk);
        check32("tmo.hold",   {29'd0, stateDbg}, 32'(ERROR));
        check32("tmo.quiet",  {29'd0, memIf.imem_req, memIf.dmem_req, pc_load}, 32'd0);
        resetPulse();
        check32("recov.flags", {30'd0, error, illegal_op}, 32'd0);

        // Async reset in the middle of a data access
        doInstr("pre", OP_ORI, 6'h00, 32'h600, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);
        opcode = OP_LW; pc_in = 32'h604;
        for (int c = 0; c < 20 && !memIf.dmem_req; c++) begin
            #1 memIf.imem_ready = memIf.imem_req;
            @(negedge clk);
        end
        memIf.imem_ready = 1'b0;
        check32("arst.inMem", 32'(memIf.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check32("arst.dmemReq", 32'(memIf.dmem_req), 32'd0);
        check32("arst.pcNext",  pc_next, RESET_PC);
        check32("arst.state",   32'(stateDbg), 32'(FETCH));
        check32("arst.count",   instr_count, 32'd0);
        check32("arst.pcLoad",  32'(pc_load), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expCount = '0;
        doInstr("post", OP_LUI, 6'h00, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control sequencer for the non-pipelined MIPS core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, with request/ready handshakes to instruction and data memory.
- Computes the next program counter (PC+4, branch, jump, jr).
- Issues the single load strobe and next-address value consumed by the program-counter register.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on pc_next during/after reset.
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 255, maximum cycles a memory request may wait for ready before ERROR (8-bit counter; must be 1..255).

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_in  in  32  current PC from program-counter register.
- pc_next  out  32  next PC to program-counter register (registered).
- pc_load  out  1  load strobe to program-counter register (registered, one-cycle pulse).
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction memory ready/data valid.
- ir_load  out  1  instruction register capture pulse.
- opcode  in  6  instr[31:26] from IR.
- funct  in  6  instr[5:0] from IR.
- imm  in  16  instr[15:0] from IR.
- jtarget  in  26  instr[25:0] from IR.
- rs_value  in  32  register-file read of rs (jr target).
- alu_zero  in  1  ALU zero flag, valid in EXECUTE.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable (sw).
- dmem_ready  in  1  data memory ready.
- rf_we  out  1  register-file write pulse.
- state  out  3  current state encoding (debug).
- illegal_op  out  1  sticky: unknown opcode seen.
- error  out  1  sticky: timeout (or misalign trap).
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (rst_n low, async):
  - State goes to FETCH.
  - pc_next = RESET_PC; instr_count = 0.
  - All strobes/requests, illegal_op and error are 0.
  - A request in flight is dropped immediately; no pc_load is generated.
- States and transitions:
  - FETCH: imem_req held high until imem_ready is sampled high. In that cycle ir_load = 1, then go to DECODE.
  - DECODE: 1 cycle, then EXECUTE. Unknown opcode sets illegal_op; the instruction is treated as a nop (PC+4, no writes).
  - EXECUTE: 1 cycle. The target is computed and registered into pc_next on exit. lw/sw go to MEMORY; beq/bne/j/jr/nop go to UPDATE; all other opcodes go to WRITEBACK.
  - MEMORY: dmem_req = 1 (dmem_we = 1 for sw) until dmem_ready. Then lw goes to WRITEBACK and sw goes to UPDATE.
  - WRITEBACK: rf_we = 1 for exactly one cycle, then UPDATE. R-type except jr, addi, andi, ori, slti, lui, lw and jal (link) pass through here.
  - UPDATE: pc_load = 1 for one cycle, instr_count += 1, then FETCH.
  - ERROR: all strobes 0; held until reset.
- pc_next stability: pc_next is stable from the cycle before pc_load rises until the next EXECUTE exit. The PC register captures on the pc_load edge.
- Next-PC rules (all 32-bit, modulo 2^32 wrap):
  - default: pc_in+4.
  - beq taken when alu_zero=1; bne taken when alu_zero=0. Taken target = pc_in+4+(sign_ext(imm)<<2).
  - j/jal: {pc_in+4[31:28], jtarget, 2'b00}.
  - jr (opcode 0, funct 0x08): rs_value.
- Latency: ALU op with zero-wait imem is 5 cycles fetch-to-pc_load; lw is 6; sw is 5; branch/jump is 4. Each memory wait cycle adds 1.
- Timeout: a separate wait counter runs in FETCH/MEMORY while ready is low. Reaching TIMEOUT sets error and enters ERROR.
- Simultaneous events: ready arriving in the same cycle the counter hits TIMEOUT counts as success.
- instr_count wraps to 0 at 2^CNT_W.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: a computed pc_next with bits[1:0] != 0 (jr only) sets error, enters ERROR from EXECUTE, and produces no pc_load.
- Undefined: pc_next[1:0] is forced to 2'b00 and execution continues.

Decomposition:
- Package pc_seq_pkg holds the state enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, UPDATE, ERROR), the opcode constants (R 0x00, j 0x02, jal 0x03, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B), FUNCT_JR 0x08 and the instruction-length constant 4.
- One combinational sub-module, pc_next_calc, produces the target from pc_in/imm/jtarget/rs_value/alu_zero/opcode/funct.

Test Plan:
- Reset: pc_in=0, zero-wait memories, addi → ir_load at cycle 1, rf_we at cycle 4, pc_load at cycle 5 with pc_next=0x4, instr_count=1.
- Branch: pc_in=0x100, beq, imm=0xFFFF, alu_zero=1 → pc_next=0x100; same with alu_zero=0 → pc_next=0x104; no rf_we.
- Jump: pc_in=0xF000_0010, j, jtarget=0x0000040 → pc_next=0xF000_0100. jal also pulses rf_we once.
- Memory wait: lw with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, pc_load 9 cycles after fetch start. sw with zero wait → dmem_we=1, no rf_we.
- Timeout/reset: imem_ready held low for 255 cycles → error=1, state=ERROR. Async rst_n pulse mid-MEMORY → dmem_req drops without clock, pc_next=RESET_PC.
- Misalign: jr, rs_value=0x102 → with macro, error=1 and no pc_load; without macro, pc_next=0x100.
